// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: op and state encodings,
// plus small decode helpers used at request acceptance.
package lsu_pkg;

  localparam int unsigned ADDR_HI_BIT = 9;
  localparam int unsigned WORD_ADDR_W = 8;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;

  typedef enum logic [2:0] {
    LW  = 3'b000,
    LH  = 3'b001,
    LHU = 3'b010,
    LB  = 3'b011,
    LBU = 3'b100,
    SW  = 3'b101,
    SH  = 3'b110,
    SB  = 3'b111
  } lsu_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_t;

  // Word ops need a 4-byte aligned address, halfword ops a 2-byte aligned one.
  function automatic logic misaligned(input lsu_op_t op, input logic [1:0] off);
    case (op)
      LW, SW:      misaligned = (off != 2'b00);
      LH, LHU, SH: misaligned = off[0];
      default:     misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input lsu_op_t op);
    is_load = (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, response and data-memory signals of the load/store unit.
// slave is the unit's view; master is the execute stage plus memory side.
interface lsu_if;
  import lsu_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  lsu_op_t                req_op;
  logic [ADDR_W-1:0]      req_addr;
  logic [DATA_W-1:0]      req_wdata;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [DATA_W-1:0]      resp_data;
  logic                   resp_err;
  logic                   mem_en;
  logic                   mem_wen;
  logic [WORD_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err,
           mem_en, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err,
           mem_en, mem_wen, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// merges sub-word store data into the old word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_op_t           op,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] rdata,
  input  logic [15:0]       sdata,
  output logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] merged
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [15:0]       half;
  logic [7:0]        byte_v;

  always_comb begin
    shamt    = {offset, 3'b000};
    shifted  = rdata >> shamt;
    half     = shifted[15:0];
    byte_v   = shifted[7:0];
    load_val = rdata;
    merged   = rdata;
    case (op)
      LH:  load_val = {{16{half[15]}}, half};
      LHU: load_val = {16'h0000, half};
      LB:  load_val = {{24{byte_v[7]}}, byte_v};
      LBU: load_val = {24'h000000, byte_v};
      SH:  merged = (rdata & ~(32'h0000_FFFF << shamt)) | (32'(sdata) << shamt);
      SB:  merged = (rdata & ~(32'h0000_00FF << shamt)) | (32'(sdata[7:0]) << shamt);
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage controller: one request at a time, word-only memory, sub-word
// stores done as read-modify-write, sign/zero-extended load responses.
module load_store_unit
  import lsu_pkg::*;
(
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  lsu_state_t             state;
  lsu_op_t                op_q;
  logic [1:0]             off_q;
  logic [15:0]            sdata_q;
  logic                   ready_q;
  logic                   resp_valid_q;
  logic [DATA_W-1:0]      resp_data_q;
  logic                   resp_err_q;
  logic                   mem_en_q;
  logic                   mem_wen_q;
  logic [WORD_ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0]      mem_wdata_q;
  logic [DATA_W-1:0]      load_val;
  logic [DATA_W-1:0]      merged;
  logic                   req_err_c;

  lsu_align u_align (
    .op       (op_q),
    .offset   (off_q),
    .rdata    (bus.mem_rdata),
    .sdata    (sdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_comb begin
    req_err_c = (bus.req_addr[ADDR_W-1:ADDR_HI_BIT+1] != '0) ||
                misaligned(bus.req_op, bus.req_addr[1:0]);
  end

  // Control outputs are flops loaded with the decode of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= LW;
      off_q        <= 2'b00;
      sdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            op_q        <= bus.req_op;
            off_q       <= bus.req_addr[1:0];
            sdata_q     <= bus.req_wdata[15:0];
            mem_addr_q  <= bus.req_addr[ADDR_HI_BIT:2];
            resp_data_q <= '0;
            resp_err_q  <= req_err_c;
            ready_q     <= 1'b0;
            if (req_err_c) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
            end else if (bus.req_op == SW) begin
              state       <= WR;
              mem_en_q    <= 1'b1;
              mem_wen_q   <= 1'b1;
              mem_wdata_q <= bus.req_wdata;
            end else begin
              state    <= RD;
              mem_en_q <= 1'b1;
            end
          end
        end
        RD: begin
          state    <= WAIT;
          mem_en_q <= 1'b0;
        end
        WAIT: begin
          if (is_load(op_q)) begin
            state        <= RESP;
            resp_data_q  <= load_val;
            resp_valid_q <= 1'b1;
          end else begin
            state       <= WR;
            mem_en_q    <= 1'b1;
            mem_wen_q   <= 1'b1;
            mem_wdata_q <= merged;
          end
        end
        WR: begin
          state        <= RESP;
          mem_en_q     <= 1'b0;
          mem_wen_q    <= 1'b0;
          mem_wdata_q  <= '0;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            ready_q      <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          mem_en_q     <= 1'b0;
          mem_wen_q    <= 1'b0;
          mem_wdata_q  <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule
